// File: rtl/eq_band_fir_if.sv
// ---------------------------------------------------------------------------
// eq_band_fir_if
//   Sample/ROM/status bundle for one equalizer band FIR engine.
//   slave  : the FIR engine (consumes samples, pot and ROM data; drives
//            ROM address, filtered samples and status flags)
//   master : the surrounding core (sample source, pot, coefficient ROM)
// Signals
//   valid      one-cycle strobe, smpl_in holds a new sample set
//   smpl_in    NUM_CH packed samples, channel c at [c*DATA_W +: DATA_W]
//   pot        unsigned band gain, unity = 2**(POT_W-1)
//   coef_addr  coefficient ROM address
//   coef       ROM data, valid one cycle after coef_addr
//   smpl_out   filtered, gain-scaled samples, same packing as smpl_in
//   out_vld    one-cycle strobe, smpl_out updated
//   sequencing high once the history buffer is primed
//   overrun    sticky, a valid strobe arrived while busy
// ---------------------------------------------------------------------------
interface eq_band_fir_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 10,
    parameter int POT_W  = 12,
    parameter int NUM_CH = 2
) ();
    logic                       valid;
    logic [NUM_CH*DATA_W-1:0]   smpl_in;
    logic [POT_W-1:0]           pot;
    logic [ADDR_W-1:0]          coef_addr;
    logic [COEF_W-1:0]          coef;
    logic [NUM_CH*DATA_W-1:0]   smpl_out;
    logic                       out_vld;
    logic                       sequencing;
    logic                       overrun;

    modport slave (
        input  valid, smpl_in, pot, coef,
        output coef_addr, smpl_out, out_vld, sequencing, overrun
    );

    modport master (
        output valid, smpl_in, pot, coef,
        input  coef_addr, smpl_out, out_vld, sequencing, overrun
    );
endinterface

// File: rtl/eq_band_fir.sv
// ---------------------------------------------------------------------------
// eq_band_fir
//   Per-band FIR engine. Keeps the last TAPS samples of every channel in a
//   circular buffer, convolves them with an external coefficient ROM (shared
//   address, one-cycle read latency) on each primed sample set, applies the
//   band pot gain and presents the result with a one-cycle out_vld strobe.
//   Raises sequencing once TAPS samples have been written.
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    eq_band_fir_if.slave (valid, smpl_in, pot, coef in;
//          coef_addr, smpl_out, out_vld, sequencing, overrun out)
// Configuration
//   EQ_SAT_EN  defined: scaled result saturates to the DATA_W signed range.
//              undefined: scaled result keeps its low DATA_W bits (wraps).
// Timing
//   valid in cycle 0 -> MAC cycles 1..TAPS -> DRAIN -> SCALE -> OUT,
//   out_vld visible in cycle TAPS+4.
// ---------------------------------------------------------------------------
module eq_band_fir #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 10,
    parameter int TAPS   = 1023,
    parameter int POT_W  = 12,
    parameter int NUM_CH = 2
) (
    input logic          clk,
    input logic          rst_n,
    eq_band_fir_if.slave bus
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
    localparam int PROD_W = ACC_W + POT_W + 1;
    localparam int SMP_W  = NUM_CH * DATA_W;

    localparam logic [ADDR_W-1:0] TAPS_A  = ADDR_W'(TAPS);
    localparam logic [ADDR_W-1:0] TAPS_M1 = ADDR_W'(TAPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        SCALE,
        OUT
    } state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          wr_ptr_q;
    logic [ADDR_W-1:0]          fill_q;
    logic [ADDR_W-1:0]          coef_addr_q;
    logic                       rd_vld_q;
    logic signed [ACC_W-1:0]    acc_q [NUM_CH];
    logic [DATA_W-1:0]          y_q   [NUM_CH];
    logic [SMP_W-1:0]           smpl_out_q;
    logic                       out_vld_q;
    logic                       sequencing_q;
    logic                       overrun_q;

    logic [SMP_W-1:0]           mem_q [DEPTH];
    logic [SMP_W-1:0]           rd_data_q;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       wr_en;

    logic signed [ACC_W-1:0]    mac_term [NUM_CH];
    logic [DATA_W-1:0]          y_lim    [NUM_CH];

    assign bus.coef_addr  = coef_addr_q;
    assign bus.smpl_out   = smpl_out_q;
    assign bus.out_vld    = out_vld_q;
    assign bus.sequencing = sequencing_q;
    assign bus.overrun    = overrun_q;

    // Samples are only accepted in IDLE; anything arriving later is dropped.
    assign wr_en = (state_q == IDLE) && bus.valid;

    // After the write wr_ptr points one past the newest sample, so
    // k = 0 addresses the oldest of the TAPS buffered samples.
    assign rd_addr = wr_ptr_q - TAPS_A + coef_addr_q;

    // History buffer: synchronous read so the sample lines up with the
    // ROM word addressed in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.smpl_in;
        end
        rd_data_q <= mem_q[rd_addr];
    end

`ifdef EQ_SAT_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [PROD_W-1:0] scaled;
`endif

    logic signed [ACC_W-1:0]  se;
    logic signed [ACC_W-1:0]  ce;
    logic signed [PROD_W-1:0] fe;
    logic signed [PROD_W-1:0] pe;

    always_comb begin
        se = '0;
        ce = '0;
        fe = '0;
        pe = {{(PROD_W-POT_W){1'b0}}, bus.pot};
`ifdef EQ_SAT_EN
        scaled = '0;
`endif
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            se          = ACC_W'(signed'(rd_data_q[c*DATA_W +: DATA_W]));
            ce          = ACC_W'(signed'(bus.coef));
            mac_term[c] = se * ce;

            fe = PROD_W'(acc_q[c] >>> (COEF_W - 1));
`ifdef EQ_SAT_EN
            scaled = (fe * pe) >>> (POT_W - 1);
            if (scaled > SAT_MAX) begin
                y_lim[c] = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (scaled < SAT_MIN) begin
                y_lim[c] = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                y_lim[c] = scaled[DATA_W-1:0];
            end
`else
            y_lim[c] = DATA_W'((fe * pe) >>> (POT_W - 1));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            coef_addr_q  <= '0;
            rd_vld_q     <= 1'b0;
            smpl_out_q   <= '0;
            out_vld_q    <= 1'b0;
            sequencing_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                y_q[c]   <= '0;
            end
        end else begin
            out_vld_q <= 1'b0;

            // rd_vld_q marks cycles where buffer data and ROM data both
            // belong to a valid tap: MAC cycles 1..TAPS-1 plus DRAIN.
            rd_vld_q <= (state_q == MAC);
            if (rd_vld_q) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    acc_q[c] <= acc_q[c] + mac_term[c];
                end
            end

            if (bus.valid && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        if (fill_q != TAPS_A) begin
                            fill_q <= fill_q + ADDR_W'(1);
                        end
                        // This write may itself be the priming one.
                        if (fill_q >= TAPS_M1) begin
                            sequencing_q <= 1'b1;
                            coef_addr_q  <= '0;
                            state_q      <= MAC;
                            for (int unsigned c = 0; c < NUM_CH; c++) begin
                                acc_q[c] <= '0;
                            end
                        end
                    end
                end
                MAC: begin
                    if (coef_addr_q == TAPS_M1) begin
                        state_q <= DRAIN;
                    end else begin
                        coef_addr_q <= coef_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= SCALE;
                end
                SCALE: begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        y_q[c] <= y_lim[c];
                    end
                    state_q <= OUT;
                end
                OUT: begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        smpl_out_q[c*DATA_W +: DATA_W] <= y_q[c];
                    end
                    out_vld_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_fir.sv
module tb_eq_band_fir;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ADDR_W = 3;
    localparam int TAPS   = 4;
    localparam int POT_W  = 12;
    localparam int NUM_CH = 2;

    logic clk;
    logic rst_n;

    int pass_cnt;
    int chk_cnt;

    logic [COEF_W-1:0] rom [2**ADDR_W];

    eq_band_fir_if #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ADDR_W(ADDR_W),
        .POT_W (POT_W),
        .NUM_CH(NUM_CH)
    ) bus ();

    eq_band_fir #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ADDR_W(ADDR_W),
        .TAPS  (TAPS),
        .POT_W (POT_W),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM with one-cycle read latency
    always @(posedge clk) bus.coef <= rom[bus.coef_addr];

    task automatic set_rom(input logic [15:0] c0, c1, c2, c3);
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 16'h0;
        rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.valid = 1'b0;
        bus.smpl_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends one sample set and waits (bounded) for out_vld.
    // lat = -1 when no out_vld shows up within the bound.
    task automatic send_get(input logic signed [15:0] l, input logic signed [15:0] r,
                            output int lat, output logic signed [15:0] ol,
                            output logic signed [15:0] orr, output logic pulse_after,
                            output logic seq_n1);
        lat = -1; ol = '0; orr = '0; pulse_after = 1'b0; seq_n1 = 1'b0;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.smpl_in = {r, l};
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            if (i == 1) seq_n1 = bus.sequencing;
            if (bus.out_vld === 1'b1) begin
                lat = i;
                ol  = bus.smpl_out[15:0];
                orr = bus.smpl_out[31:16];
                @(negedge clk);
                pulse_after = bus.out_vld;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.pot = 12'h800;
        set_rom(16'h2000, 16'h2000, 16'h2000, 16'h2000);
        do_reset();
        chk_cnt++; if (bus.smpl_out !== 32'h0) $display("FAIL reset_smpl_out got=%h exp=0", bus.smpl_out); else pass_cnt++;
        chk_cnt++; if (bus.out_vld !== 1'b0) $display("FAIL reset_out_vld got=%b exp=0", bus.out_vld); else pass_cnt++;
        chk_cnt++; if (bus.sequencing !== 1'b0) $display("FAIL reset_sequencing got=%b exp=0", bus.sequencing); else pass_cnt++;
        chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
        chk_cnt++; if (bus.coef_addr !== 3'd0) $display("FAIL reset_coef_addr got=%0d exp=0", bus.coef_addr); else pass_cnt++;
    endtask

    task automatic test_priming();
        int lat; logic signed [15:0] ol, orr; logic pa, s1;
        for (int n = 0; n < 3; n++) begin
            send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
            chk_cnt++; if (lat !== -1) $display("FAIL prime_no_out n=%0d got_lat=%0d exp=-1", n, lat); else pass_cnt++;
            chk_cnt++; if (bus.smpl_out !== 32'h0) $display("FAIL prime_smpl_zero n=%0d got=%h exp=0", n, bus.smpl_out); else pass_cnt++;
        end
        chk_cnt++; if (bus.sequencing !== 1'b0) $display("FAIL prime_seq_low got=%b exp=0", bus.sequencing); else pass_cnt++;
        send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
        chk_cnt++; if (s1 !== 1'b1) $display("FAIL prime_seq_rise got=%b exp=1", s1); else pass_cnt++;
        chk_cnt++; if (lat !== 8) $display("FAIL prime_latency got=%0d exp=8", lat); else pass_cnt++;
        chk_cnt++; if (ol !== 16'sd1000) $display("FAIL prime_dc_l got=%0d exp=1000", ol); else pass_cnt++;
        chk_cnt++; if (orr !== 16'sd1000) $display("FAIL prime_dc_r got=%0d exp=1000", orr); else pass_cnt++;
        chk_cnt++; if (pa !== 1'b0) $display("FAIL out_vld_width got=%b exp=0", pa); else pass_cnt++;
        chk_cnt++; if (bus.smpl_out !== {16'sd1000, 16'sd1000}) $display("FAIL smpl_out_hold got=%h exp=03e803e8", bus.smpl_out); else pass_cnt++;
    endtask

    task automatic test_wrap_dc();
        int lat; logic signed [15:0] ol, orr; logic pa, s1;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
            if (n >= 3) begin
                chk_cnt++;
                if (lat !== 8 || ol !== 16'sd1000 || orr !== 16'sd1000)
                    $display("FAIL wrap_dc n=%0d got lat=%0d l=%0d r=%0d exp lat=8 l=1000 r=1000", n, lat, ol, orr);
                else pass_cnt++;
            end
        end
        bus.pot = 12'h400;
        send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
        chk_cnt++; if (ol !== 16'sd500 || orr !== 16'sd500) $display("FAIL pot_half got l=%0d r=%0d exp 500", ol, orr); else pass_cnt++;
        bus.pot = 12'h800;
    endtask

    task automatic test_impulse();
        int lat; logic signed [15:0] ol, orr; logic pa, s1;
        int exp_v [5];
        exp_v = '{4096, 3072, 2048, 1024, 0};
        set_rom(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        do_reset();
        for (int n = 0; n < 3; n++) send_get(16'sd0, 16'sd0, lat, ol, orr, pa, s1);
        for (int n = 0; n < 5; n++) begin
            if (n == 0) send_get(16'sd8192, -16'sd8192, lat, ol, orr, pa, s1);
            else        send_get(16'sd0, 16'sd0, lat, ol, orr, pa, s1);
            chk_cnt++;
            if (lat !== 8 || ol !== 16'(exp_v[n]) || orr !== 16'(-exp_v[n]))
                $display("FAIL impulse n=%0d got lat=%0d l=%0d r=%0d exp l=%0d r=%0d", n, lat, ol, orr, exp_v[n], -exp_v[n]);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        int lat; logic signed [15:0] ol, orr; logic pa, s1;
        logic signed [15:0] exp_l, exp_r;
`ifdef EQ_SAT_EN
        exp_l = 16'sh7FFF; exp_r = 16'sh8000;
`else
        exp_l = -16'sd5536; exp_r = 16'sd5536;
`endif
        set_rom(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        do_reset();
        for (int n = 0; n < 4; n++) send_get(16'sd30000, -16'sd30000, lat, ol, orr, pa, s1);
        chk_cnt++; if (ol !== exp_l) $display("FAIL sat_pos got=%0d exp=%0d", ol, exp_l); else pass_cnt++;
        chk_cnt++; if (orr !== exp_r) $display("FAIL sat_neg got=%0d exp=%0d", orr, exp_r); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int lat; logic signed [15:0] ol, orr; logic pa, s1;
        set_rom(16'h2000, 16'h2000, 16'h2000, 16'h2000);
        do_reset();
        for (int n = 0; n < 4; n++) send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
        chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL overrun_clear got=%b exp=0", bus.overrun); else pass_cnt++;
        lat = -1;
        @(negedge clk); bus.valid = 1'b1; bus.smpl_in = {16'sd1000, 16'sd1000};
        @(negedge clk); bus.valid = 1'b0;
        @(negedge clk); bus.valid = 1'b1; bus.smpl_in = {16'sd5000, 16'sd5000};
        @(negedge clk); bus.valid = 1'b0;
        chk_cnt++; if (bus.overrun !== 1'b1) $display("FAIL overrun_set got=%b exp=1", bus.overrun); else pass_cnt++;
        for (int i = 4; i <= 14; i++) begin
            @(negedge clk);
            if (bus.out_vld === 1'b1) begin lat = i; ol = bus.smpl_out[15:0]; break; end
        end
        chk_cnt++; if (lat !== 8 || ol !== 16'sd1000) $display("FAIL overrun_pending got lat=%0d l=%0d exp lat=8 l=1000", lat, ol); else pass_cnt++;
        send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
        chk_cnt++; if (ol !== 16'sd1000 || orr !== 16'sd1000) $display("FAIL overrun_dropped got l=%0d r=%0d exp 1000", ol, orr); else pass_cnt++;
        chk_cnt++; if (bus.overrun !== 1'b1) $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; logic signed [15:0] ol;
        lat = -1; ol = '0;
        @(negedge clk); bus.valid = 1'b1; bus.smpl_in = {16'sd1000, 16'sd1000};
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            if (i == 7) begin bus.valid = 1'b1; bus.smpl_in = {16'sd9000, 16'sd9000}; end
            if (i == 8) begin
                chk_cnt++; if (bus.out_vld !== 1'b1) $display("FAIL b2b_first_vld got=%b exp=1", bus.out_vld); else pass_cnt++;
                bus.valid = 1'b1; bus.smpl_in = {16'sd1000, 16'sd1000};
            end
        end
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            bus.valid = 1'b0;
            if (bus.out_vld === 1'b1) begin lat = i; ol = bus.smpl_out[15:0]; break; end
        end
        chk_cnt++; if (lat !== 8 || ol !== 16'sd1000) $display("FAIL b2b_second got lat=%0d l=%0d exp lat=8 l=1000", lat, ol); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mac();
        int lat; int vld_seen; logic signed [15:0] ol, orr; logic pa, s1;
        vld_seen = 0;
        @(negedge clk); bus.valid = 1'b1; bus.smpl_in = {16'sd1000, 16'sd1000};
        @(negedge clk); bus.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.smpl_out !== 32'h0 || bus.out_vld !== 1'b0 || bus.sequencing !== 1'b0 ||
            bus.overrun !== 1'b0 || bus.coef_addr !== 3'd0)
            $display("FAIL rst_mid_mac got out=%h vld=%b seq=%b ovr=%b addr=%0d exp all 0",
                     bus.smpl_out, bus.out_vld, bus.sequencing, bus.overrun, bus.coef_addr);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_vld === 1'b1) vld_seen++;
        end
        chk_cnt++; if (vld_seen !== 0) $display("FAIL rst_no_out_vld got=%0d exp=0", vld_seen); else pass_cnt++;
        for (int n = 0; n < 3; n++) begin
            send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
            chk_cnt++; if (lat !== -1) $display("FAIL reprime_no_out n=%0d got_lat=%0d exp=-1", n, lat); else pass_cnt++;
        end
        chk_cnt++; if (bus.sequencing !== 1'b0) $display("FAIL reprime_seq_low got=%b exp=0", bus.sequencing); else pass_cnt++;
        send_get(16'sd1000, 16'sd1000, lat, ol, orr, pa, s1);
        chk_cnt++; if (lat !== 8 || ol !== 16'sd1000) $display("FAIL reprime_out got lat=%0d l=%0d exp lat=8 l=1000", lat, ol); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n = 1'b0;
        bus.valid = 1'b0;
        bus.smpl_in = '0;
        bus.pot = 12'h800;
        test_reset();
        test_priming();
        test_wrap_dc();
        test_impulse();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
